// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache, one 32-bit word per line,
// 2^INDEX_W lines, zero-latency hits and a blocking single-refill miss path.
//
// Optional feature macro: ICACHE_PERF_EN adds saturating hit/miss counters.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   inst_ren, inst_addr  fetch request and byte address (bits [1:0] ignored)
//   inst_data            fetched word (combinational, 0 when not delivering)
//   inst_stall           word not yet available
//   flush                invalidate all lines at the next edge
//   mem_req, mem_addr    refill request and word-aligned refill address
//   mem_ack, mem_rdata   single-cycle refill acknowledge with data
//   hit_cnt, miss_cnt    performance counters (ICACHE_PERF_EN only)
//
// state | meaning
// IDLE  | lookup; hits served in the same cycle, a miss latches its address
// WAIT  | refill outstanding; mem_req held until mem_ack writes the line
module inst_cache #(
    parameter int INDEX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;

    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];
    logic [29:0]        miss_addr;          // latched word address of the miss

    logic [INDEX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               hit, miss_start, refill;
    logic               unused_addr_bits;

    assign idx      = inst_addr[INDEX_W+1:2];
    assign tag      = inst_addr[31:INDEX_W+2];
    assign fill_idx = miss_addr[INDEX_W-1:0];
    assign fill_tag = miss_addr[29:INDEX_W];
    assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
    assign unused_addr_bits = ^inst_addr[1:0];

    always_comb begin
        state_nxt  = state;
        inst_data  = '0;
        inst_stall = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        miss_start = 1'b0;
        refill     = 1'b0;
        case (state)
            IDLE: begin
                if (inst_ren) begin
                    if (hit) begin
                        inst_data = data_mem[idx];
                    end else begin
                        inst_stall = 1'b1;
                        miss_start = 1'b1;
                        state_nxt  = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_req    = 1'b1;
                mem_addr   = {miss_addr, 2'b00};
                inst_stall = 1'b1;
                if (mem_ack) begin
                    refill    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Flush wipes everything, but a refill landing on the same edge survives.
    always_comb begin
        valid_d = flush ? '0 : valid_q;
        if (refill) valid_d[fill_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_q   <= '0;
            miss_addr <= '0;
        end else begin
            state   <= state_nxt;
            valid_q <= valid_d;
            if (miss_start) miss_addr <= inst_addr[31:2];
        end
    end

    always_ff @(posedge clk) begin
        if (refill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rdata;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == IDLE && inst_ren && hit && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_start && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
